// File: rtl/ca90_iter_gen_unit.sv
// ca90_iter_gen_unit: sequential rule-90 cellular-automaton item-memory generator.
// Iterates v <- rotl(v, s) ^ rotr(v, s) a runtime-chosen number of times,
// one step per clock, and returns the result over a valid/ready handshake.
// Optional feature macro: CA90_ITER_CHAIN_EN (chain_i restarts from the last
// result instead of seed_i). With the macro undefined chain_i is ignored.
module ca90_iter_gen_unit #(
    parameter int unsigned Dimension  = 512,
    parameter int unsigned MaxIter    = 1023,
    parameter int unsigned IterWidth  = $clog2(MaxIter + 1),
    parameter int unsigned ShiftWidth = $clog2(Dimension)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [Dimension-1:0]  seed_i,
    input  logic [ShiftWidth-1:0] shift_amt_i,
    input  logic [IterWidth-1:0]  num_iter_i,
    input  logic                  chain_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic [Dimension-1:0]  vector_o,
    output logic                  vector_valid_o,
    input  logic                  vector_ready_i,
    output logic                  busy_o
);

    localparam int unsigned SelWidth = ShiftWidth + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e                  fsm_q, fsm_d;
    logic [Dimension-1:0]  state_q;
    logic [IterWidth-1:0]  cnt_q;
    logic [IterWidth-1:0]  num_q;
    logic [ShiftWidth-1:0] shift_q;

    logic                  accept;
    logic                  step;
    logic [IterWidth-1:0]  num_eff;
    logic [ShiftWidth-1:0] shift_eff;
    logic [Dimension-1:0]  start_vec;
    logic [Dimension-1:0]  ca_next;
    logic [2*Dimension-1:0] dbl;
    logic [SelWidth-1:0]   rsel;
    logic [SelWidth-1:0]   lsel;

    // Sanitise request fields: clamp the iteration count, coerce shift 0 to 1.
    always_comb begin
        num_eff   = (num_iter_i > IterWidth'(MaxIter)) ? IterWidth'(MaxIter) : num_iter_i;
        shift_eff = (shift_amt_i == '0) ? ShiftWidth'(1) : shift_amt_i;
    end

`ifdef CA90_ITER_CHAIN_EN
    // Starting vector: last result when chaining, otherwise the supplied seed.
    always_comb begin
        start_vec = chain_i ? state_q : seed_i;
    end
`else
    logic chain_unused;
    assign chain_unused = chain_i;

    // Starting vector: every request loads the supplied seed.
    always_comb begin
        start_vec = seed_i;
    end
`endif

    // One rule-90 step; both rotates are windows into the doubled vector,
    // rotr at offset s and rotl at offset D-s (s is never 0 here).
    always_comb begin
        dbl     = {state_q, state_q};
        rsel    = {1'b0, shift_q};
        lsel    = SelWidth'(Dimension) - rsel;
        ca_next = dbl[rsel +: Dimension] ^ dbl[lsel +: Dimension];
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        fsm_d          = fsm_q;
        accept         = 1'b0;
        step           = 1'b0;
        req_ready_o    = 1'b0;
        vector_valid_o = 1'b0;
        busy_o         = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept = 1'b1;
                    fsm_d  = (num_eff == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                step   = 1'b1;
                if (cnt_q == num_q - IterWidth'(1)) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                busy_o         = 1'b1;
                vector_valid_o = 1'b1;
                if (vector_ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Datapath: latch the request on accept, then apply one step per RUN cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            shift_q <= '0;
        end else if (accept) begin
            state_q <= start_vec;
            cnt_q   <= '0;
            num_q   <= num_eff;
            shift_q <= shift_eff;
        end else if (step) begin
            state_q <= ca_next;
            cnt_q   <= cnt_q + IterWidth'(1);
        end
    end

    assign vector_o = state_q;

endmodule
